// File: rtl/aes_pkg.sv
// Shared definitions for the AES round sequencer: block width, round counts
// for the two supported key sizes, and the sequencer FSM state encoding.
package aes_pkg;

  localparam int AES_BLOCK_W = 128;
  localparam int NR_AES128   = 10;
  localparam int NR_AES256   = 14;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2,
    S_OUT    = 2'd3
  } seq_state_e;

endpackage

// File: rtl/aes_round_sequencer.sv
// AES round sequencer: accepts a plaintext block, applies the initial
// AddRoundKey, then drives NR rounds through an external pipelined round
// datapath, adding each round key to the returned state. The finished
// ciphertext is held on out_block until the consumer takes it.
module aes_round_sequencer
  import aes_pkg::*;
#(
  parameter int NR     = NR_AES128,
  parameter int DP_LAT = 3
) (
  input  logic                   clk,
  input  logic                   asy_reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [AES_BLOCK_W-1:0] in_block,
  output logic [3:0]             rk_idx,
  input  logic [AES_BLOCK_W-1:0] rk_data,
  output logic                   dp_launch,
  output logic [AES_BLOCK_W-1:0] dp_state,
  output logic                   dp_last,
  input  logic [AES_BLOCK_W-1:0] dp_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [AES_BLOCK_W-1:0] out_block,
  output logic                   busy
);

  // The wait counter only has to hold DP_LAT-1; keep at least one bit so
  // DP_LAT=1 still elaborates.
  localparam int                WCNT_W     = (DP_LAT > 1) ? $clog2(DP_LAT) : 1;
  localparam logic [WCNT_W-1:0] WCNT_INIT  = WCNT_W'(DP_LAT - 1);
  localparam logic [WCNT_W-1:0] WCNT_ONE   = WCNT_W'(1);
  localparam logic [3:0]        ROUND_LAST = 4'(NR);

  seq_state_e             state_q,     state_d;
  logic [AES_BLOCK_W-1:0] state_reg_q, state_reg_d;
  logic [3:0]             round_q,     round_d;
  logic [WCNT_W-1:0]      wcnt_q,      wcnt_d;

  logic                   in_ready_q,  in_ready_d;
  logic                   busy_q,      busy_d;
  logic [3:0]             rk_idx_q,    rk_idx_d;
  logic                   dp_launch_q, dp_launch_d;
  logic [AES_BLOCK_W-1:0] dp_state_q,  dp_state_d;
  logic                   dp_last_q,   dp_last_d;
  logic                   out_valid_q, out_valid_d;
  logic [AES_BLOCK_W-1:0] out_block_q, out_block_d;

  // Next-state logic for the FSM, round counter, wait counter and AddRoundKey,
  // followed by output decode from the next state so every output is a flop.
  always_comb begin
    state_d     = state_q;
    state_reg_d = state_reg_q;
    round_d     = round_q;
    wcnt_d      = wcnt_q;

    unique case (state_q)
      S_IDLE: begin
        // rk_idx is 0 while idle, so rk_data is the whitening key here.
        if (in_valid) begin
          state_reg_d = in_block ^ rk_data;
          round_d     = 4'd1;
          state_d     = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        wcnt_d  = WCNT_INIT;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // dp_in is only meaningful on the final wait cycle; rk_idx already
        // equals round, so rk_data is this round's key.
        if (wcnt_q == '0) begin
          state_reg_d = dp_in ^ rk_data;
          if (round_q == ROUND_LAST) begin
            state_d = S_OUT;
          end else begin
            round_d = round_q + 4'd1;
            state_d = S_LAUNCH;
          end
        end else begin
          wcnt_d = wcnt_q - WCNT_ONE;
        end
      end
      S_OUT: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    in_ready_d  = (state_d == S_IDLE);
    busy_d      = (state_d != S_IDLE);
    dp_launch_d = (state_d == S_LAUNCH);
    rk_idx_d    = ((state_d == S_LAUNCH) || (state_d == S_WAIT)) ? round_d : 4'd0;
    // Datapath operands are captured on launch and then left alone so the
    // datapath may sample them at any point of its own pipeline.
    dp_state_d  = dp_launch_d ? state_reg_d : dp_state_q;
    dp_last_d   = dp_launch_d ? (round_d == ROUND_LAST) : dp_last_q;
    out_valid_d = (state_d == S_OUT);
    out_block_d = out_valid_d ? state_reg_d : out_block_q;
  end

  // State and output registers; reset clears everything and abandons any block.
  always_ff @(posedge clk or negedge asy_reset) begin
    if (!asy_reset) begin
      state_q     <= S_IDLE;
      state_reg_q <= '0;
      round_q     <= 4'd0;
      wcnt_q      <= '0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
      rk_idx_q    <= 4'd0;
      dp_launch_q <= 1'b0;
      dp_state_q  <= '0;
      dp_last_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_block_q <= '0;
    end else begin
      state_q     <= state_d;
      state_reg_q <= state_reg_d;
      round_q     <= round_d;
      wcnt_q      <= wcnt_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
      rk_idx_q    <= rk_idx_d;
      dp_launch_q <= dp_launch_d;
      dp_state_q  <= dp_state_d;
      dp_last_q   <= dp_last_d;
      out_valid_q <= out_valid_d;
      out_block_q <= out_block_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign busy      = busy_q;
  assign rk_idx    = rk_idx_q;
  assign dp_launch = dp_launch_q;
  assign dp_state  = dp_state_q;
  assign dp_last   = dp_last_q;
  assign out_valid = out_valid_q;
  assign out_block = out_block_q;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Bench for aes_round_sequencer: two instances (AES-128 with a 3-stage
// datapath, AES-256 with a 1-stage datapath), each with a behavioural AES
// round datapath and key schedule, checked against a full AES reference.
module tb_aes_round_sequencer;
  import aes_pkg::*;

  localparam int NR0 = NR_AES128;
  localparam int LAT0 = 3;
  localparam int NR1 = NR_AES256;
  localparam int LAT1 = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic asy_reset;

  logic         in_valid0, in_ready0, dp_launch0, dp_last0, out_valid0, out_ready0, busy0;
  logic [127:0] in_block0, rk_data0, dp_state0, dp_in0, out_block0;
  logic [3:0]   rk_idx0;
  logic         in_valid1, in_ready1, dp_launch1, dp_last1, out_valid1, out_ready1, busy1;
  logic [127:0] in_block1, rk_data1, dp_state1, dp_in1, out_block1;
  logic [3:0]   rk_idx1;

  logic [127:0] rk0 [0:15];
  logic [127:0] rk1 [0:15];
  logic [127:0] pipe0 [0:LAT0-1];
  logic [127:0] pipe1 [0:LAT1-1];
  logic [7:0]   sbox [0:255];

  int total = 0;
  int bad = 0;

  aes_round_sequencer #(.NR(NR0), .DP_LAT(LAT0)) dut0 (
    .clk(clk), .asy_reset(asy_reset),
    .in_valid(in_valid0), .in_ready(in_ready0), .in_block(in_block0),
    .rk_idx(rk_idx0), .rk_data(rk_data0),
    .dp_launch(dp_launch0), .dp_state(dp_state0), .dp_last(dp_last0), .dp_in(dp_in0),
    .out_valid(out_valid0), .out_ready(out_ready0), .out_block(out_block0),
    .busy(busy0)
  );

  aes_round_sequencer #(.NR(NR1), .DP_LAT(LAT1)) dut1 (
    .clk(clk), .asy_reset(asy_reset),
    .in_valid(in_valid1), .in_ready(in_ready1), .in_block(in_block1),
    .rk_idx(rk_idx1), .rk_data(rk_data1),
    .dp_launch(dp_launch1), .dp_state(dp_state1), .dp_last(dp_last1), .dp_in(dp_in1),
    .out_valid(out_valid1), .out_ready(out_ready1), .out_block(out_block1),
    .busy(busy1)
  );

  // ---------------- AES reference arithmetic ----------------
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rol8(input logic [7:0] v, input int n);
    logic [15:0] d;
    d = {v, v} << n;
    return d[15:8];
  endfunction

  function automatic logic [7:0] sbox_calc(input logic [7:0] a);
    logic [7:0] inv;
    inv = 8'h01;
    for (int j = 0; j < 254; j++) inv = gm(inv, a);
    return inv ^ rol8(inv, 1) ^ rol8(inv, 2) ^ rol8(inv, 3) ^ rol8(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] t);
    return {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]};
  endfunction

  function automatic logic [127:0] aes_round(input logic [127:0] st, input logic last);
    logic [7:0] a [0:15];
    logic [7:0] b [0:15];
    logic [7:0] x0, x1, x2, x3;
    logic [127:0] o;
    for (int i = 0; i < 16; i++) a[i] = sbox[st[127-8*i -: 8]];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) b[r+4*c] = a[r+4*((c+r)%4)];
    if (!last) begin
      for (int c = 0; c < 4; c++) begin
        x0 = b[4*c]; x1 = b[4*c+1]; x2 = b[4*c+2]; x3 = b[4*c+3];
        b[4*c]   = xt(x0) ^ (xt(x1) ^ x1) ^ x2 ^ x3;
        b[4*c+1] = x0 ^ xt(x1) ^ (xt(x2) ^ x2) ^ x3;
        b[4*c+2] = x0 ^ x1 ^ xt(x2) ^ (xt(x3) ^ x3);
        b[4*c+3] = (xt(x0) ^ x0) ^ x1 ^ x2 ^ xt(x3);
      end
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = b[i];
    return o;
  endfunction

  function automatic logic [127:0] ref_enc(input logic [127:0] pt, input int nr, input bit sel);
    logic [127:0] s;
    s = pt ^ (sel ? rk1[0] : rk0[0]);
    for (int r = 1; r <= nr; r++) s = aes_round(s, r == nr) ^ (sel ? rk1[r] : rk0[r]);
    return s;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic set_key(input logic [255:0] key, input int nk, input int nr, input bit sel);
    logic [31:0] w [0:63];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
        rc = xt(rc);
      end else if (nk > 6 && i % nk == 4) begin
        t = subw(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r <= nr; r++) begin
      if (sel) rk1[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      else     rk0[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    end
  endtask

  // ---------------- key schedule lookup and round datapath models ----------------
  assign rk_data0 = rk0[rk_idx0];
  assign rk_data1 = rk1[rk_idx1];
  assign dp_in0   = pipe0[LAT0-1];
  assign dp_in1   = pipe1[LAT1-1];

  // Pipelined datapath; junk enters whenever no round is launched.
  always @(posedge clk) begin
    pipe0[0] <= dp_launch0 ? aes_round(dp_state0, dp_last0) : rnd128();
    for (int i = 1; i < LAT0; i++) pipe0[i] <= pipe0[i-1];
    pipe1[0] <= dp_launch1 ? aes_round(dp_state1, dp_last1) : rnd128();
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One block through dut0: optional output stall, optional reset abort at cycle abort_k.
  task automatic run0(input logic [127:0] pt, input int hold, input int abort_k, input bit fips);
    logic [127:0] exp_ct, held;
    int k, nl, out_k, rnd;
    bit seen;
    exp_ct = ref_enc(pt, NR0, 1'b0);
    @(negedge clk);
    chk("idle_in_ready", in_ready0, 1);
    chk("idle_rk_idx", rk_idx0, 0);
    in_block0 = pt;
    in_valid0 = 1'b1;
    @(posedge clk);
    k = 0; nl = 0; out_k = -1;
    while (out_k < 0 && k < 200) begin
      @(negedge clk);
      k++;
      in_block0 = rnd128();
      if (abort_k != 0 && k == abort_k) begin
        asy_reset = 1'b0;
        out_ready0 = 1'b0;
        in_valid0 = 1'b0;
        #1;
        chk("rst_out_valid", out_valid0, 0);
        chk("rst_dp_launch", dp_launch0, 0);
        chk("rst_dp_last", dp_last0, 0);
        chk("rst_busy", busy0, 0);
        chk("rst_rk_idx", rk_idx0, 0);
        chk("rst_dp_state", dp_state0, 0);
        chk("rst_out_block", out_block0, 0);
        @(negedge clk);
        @(negedge clk);
        asy_reset = 1'b1;
        #1;
        chk("rel_in_ready", in_ready0, 1);
        seen = 1'b0;
        repeat (60) begin
          @(negedge clk);
          if (out_valid0 !== 1'b0 || busy0 !== 1'b0) seen = 1'b1;
        end
        chk("abort_no_output", seen, 0);
        return;
      end
      if (out_valid0 === 1'b1) begin
        out_k = k;
        out_ready0 = 1'b0;
      end else begin
        out_ready0 = 1'($urandom);
        chk("busy", busy0, 1);
        chk("in_ready_busy", in_ready0, 0);
        chk("dp_launch_timing", dp_launch0, ((k-1) % (LAT0+1)) == 0);
        if (((k-1) % (LAT0+1)) != 0) chk("rk_idx_wait", rk_idx0, (k-1)/(LAT0+1) + 1);
        if (dp_launch0 === 1'b1) begin
          nl++;
          chk("dp_last", dp_last0, nl == NR0);
        end
      end
    end
    chk("latency", out_k, NR0*(1+LAT0)+1);
    chk("launch_count", nl, NR0);
    chk("ciphertext", out_block0, exp_ct);
    if (fips) chk("fips128", out_block0, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    held = out_block0;
    repeat (hold) begin
      @(negedge clk);
      rnd = int'($urandom_range(0, 1));
      in_block0 = rnd128();
      chk("stall_out_valid", out_valid0, 1);
      chk("stall_out_block", out_block0, held);
      chk("stall_in_ready", in_ready0, 0);
    end
    out_ready0 = 1'b1;
    @(posedge clk);
    #1;
    out_ready0 = 1'b0;
    in_valid0 = 1'b0;
    chk("post_hs_out_valid", out_valid0, 0);
    chk("post_hs_busy", busy0, 0);
    chk("post_hs_in_ready", in_ready0, 1);
  endtask

  task automatic run1(input logic [127:0] pt, input bit fips);
    logic [127:0] exp_ct;
    int k, out_k;
    exp_ct = ref_enc(pt, NR1, 1'b1);
    @(negedge clk);
    chk("d1_in_ready", in_ready1, 1);
    in_block1 = pt;
    in_valid1 = 1'b1;
    @(posedge clk);
    k = 0; out_k = -1;
    while (out_k < 0 && k < 100) begin
      @(negedge clk);
      k++;
      in_valid1 = 1'b0;
      if (out_valid1 === 1'b1) out_k = k;
      else chk("d1_busy", busy1, 1);
    end
    chk("d1_latency", out_k, NR1*(1+LAT1)+1);
    chk("d1_ciphertext", out_block1, exp_ct);
    if (fips) chk("fips256", out_block1, 128'h8ea2b7ca516745bfeafc49904b496089);
    out_ready1 = 1'b1;
    @(posedge clk);
    #1;
    out_ready1 = 1'b0;
    chk("d1_post_hs", out_valid1, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] pt_a, pt_b;
    for (int a = 0; a < 256; a++) sbox[a] = sbox_calc(8'(a));
    for (int i = 0; i < 16; i++) begin
      rk0[i] = '0;
      rk1[i] = '0;
    end
    asy_reset = 1'b1;
    in_valid0 = 1'b0; in_block0 = '0; out_ready0 = 1'b0;
    in_valid1 = 1'b0; in_block1 = '0; out_ready1 = 1'b0;
    #1 asy_reset = 1'b0;
    #1;
    chk("reset_out_valid", out_valid0, 0);
    chk("reset_busy", busy0, 0);
    chk("reset_dp_launch", dp_launch0, 0);
    chk("reset_rk_idx", rk_idx0, 0);
    chk("reset_out_block", out_block0, 0);
    chk("reset_d1_out_valid", out_valid1, 0);
    repeat (3) @(negedge clk);
    asy_reset = 1'b1;
    #1;
    chk("reset_release_in_ready", in_ready0, 1);
    chk("reset_release_d1_in_ready", in_ready1, 1);

    // FIPS-197 AES-128 vector with a 20-cycle output stall
    set_key({128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4, NR0, 1'b0);
    run0(128'h00112233445566778899aabbccddeeff, 20, 0, 1'b1);

    // back-to-back random blocks
    pt_a = rnd128();
    pt_b = rnd128();
    run0(pt_a, 0, 0, 1'b0);
    run0(pt_b, 3, 0, 1'b0);

    // fresh random key
    set_key({rnd128(), 128'h0}, 4, NR0, 1'b0);
    run0(rnd128(), 1, 0, 1'b0);

    // reset in the middle of round 5, then a clean FIPS block
    run0(rnd128(), 0, 18, 1'b0);
    set_key({128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4, NR0, 1'b0);
    run0(128'h00112233445566778899aabbccddeeff, 0, 0, 1'b1);

    // AES-256 with a single-stage datapath
    set_key(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8, NR1, 1'b1);
    run1(128'h00112233445566778899aabbccddeeff, 1'b1);
    set_key({rnd128(), rnd128()}, 8, NR1, 1'b1);
    run1(rnd128(), 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/aes_round_sequencer.md
AES_ROUND_SEQUENCER -- requirements
Module: aes_round_sequencer

Interface
REQ-001 Parameters SHALL be:
- NR, 10, number of AES rounds (10/14 for AES-128/256).
- DP_LAT, 3, register stages in the external round datapath (sub_bytes, shift_rows, mix_columns); must be at least 1.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk  in  1  clock, rising edge.
- asy_reset  in  1  reset, asynchronous, active-low.
- in_valid  in  1  plaintext block offered.
- in_ready  out  1  block accepted when in_valid&in_ready.
- in_block  in  128  plaintext, column-major byte order.
- rk_idx  out  4  round-key index requested from the key schedule.
- rk_data  in  128  round key for rk_idx, valid the same cycle (combinational lookup).
- dp_launch  out  1  one-cycle pulse that starts a datapath round.
- dp_state  out  128  state presented to the datapath.
- dp_last  out  1  final round; datapath bypasses MixColumns.
- dp_in  in  128  datapath result, valid DP_LAT cycles after dp_launch.
- out_valid  out  1  ciphertext available.
- out_ready  in  1  ciphertext consumed when out_valid&out_ready.
- out_block  out  128  ciphertext.
- busy  out  1  high in every state except IDLE.

Function
REQ-003 The FSM SHALL have four states: IDLE, LAUNCH, WAIT and OUT.
REQ-004 IDLE behaviour:
- in_ready=1 and rk_idx=0.
- On in_valid: state_reg <= in_block ^ rk_data, round <= 1, next state LAUNCH.
REQ-005 LAUNCH behaviour:
- Lasts one cycle.
- dp_launch=1, dp_state=state_reg, dp_last=(round==NR).
- Load wait counter with DP_LAT-1.
- Next state WAIT.
REQ-006 WAIT behaviour:
- Lasts exactly DP_LAT cycles; rk_idx=round throughout.
- On the last WAIT cycle: state_reg <= dp_in ^ rk_data.
- Then, if round==NR, next state OUT; otherwise round++ and next state LAUNCH.
REQ-007 OUT behaviour:
- out_valid=1, out_block=state_reg, both held stable until out_ready.
- On out_valid&out_ready, next state IDLE.
- in_ready is low in OUT, so accept is never in the same cycle as output.
REQ-008 Latency: with the accept cycle numbered 0, out_valid SHALL first be high in cycle NR*(1+DP_LAT)+1 (41 at the defaults).
REQ-009 Outside LAUNCH, dp_launch SHALL be 0; dp_state and dp_last keep their last values.
REQ-010 in_valid SHALL be ignored in every state except IDLE; out_ready SHALL be ignored unless out_valid=1.
REQ-011 round SHALL be 4 bits wide, count 1..NR, and never wrap past NR.
REQ-012 dp_in SHALL be sampled only on the last WAIT cycle; its value at any other time has no effect.

Reset
REQ-013 While asy_reset=0, the block SHALL force, asynchronously:
- state to IDLE, state_reg=0, round=0, wait counter=0;
- out_valid=0, dp_launch=0, dp_last=0, busy=0, rk_idx=0, dp_state=0, out_block=0.
REQ-014 Reset asserted mid-operation SHALL abandon the block in flight, with no out_valid pulse afterwards.
REQ-015 in_ready SHALL be 1 in the first cycle after reset deasserts.

Structure
REQ-016 Package aes_pkg SHALL hold:
- the FSM state enum;
- AES_BLOCK_W=128;
- NR_AES128=10 and NR_AES256=14.
REQ-017 The block SHALL have no sub-module: the FSM, round counter, wait counter and AddRoundKey XOR are implemented flat.

Verification
REQ-018 The bench SHALL cover these directed scenarios:
- FIPS-197 vector: key 000102..0f and plaintext 00112233445566778899aabbccddeeff, with a reference 3-stage datapath and key-schedule model -> out_block=69c4e0d86a7b0430d8cdb78070b4c55a in cycle 41.
- dp_launch check -> exactly 10 pulses per block, spaced 4 cycles apart; dp_last=1 only on the 10th; rk_idx steps 0,1..10.
- out_ready held low 20 cycles -> out_valid and out_block stable throughout; in_ready stays 0; no new accept.
- Back-to-back in_valid -> second block accepted no earlier than one cycle after the output handshake; both ciphertexts correct.
- asy_reset pulsed during round 5 -> all outputs 0 immediately; in_ready=1 after release; next block encrypts correctly.
- DP_LAT=1, NR=14 -> out_valid in cycle 29; result matches the reference model.
